// File: rtl/ahb_rr_arbiter_if.sv
// Request/grant bundle between three AHB masters and the round-robin arbiter.
// The arbiter connects through the slave modport; the master modport drives requests.
interface ahb_rr_arbiter_if;
    logic [2:0] hbusreq;
    logic [2:0] hlock;
    logic [1:0] htrans;
    logic       hready;
    logic [2:0] hgrant;
    logic [1:0] hmaster;
    logic [1:0] hmaster_data;
    logic       hmastlock;

    modport master (
        output hbusreq, hlock, htrans, hready,
        input  hgrant, hmaster, hmaster_data, hmastlock
    );

    modport slave (
        input  hbusreq, hlock, htrans, hready,
        output hgrant, hmaster, hmaster_data, hmastlock
    );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Three-master AHB round-robin arbiter with locked transfers and a beat-count hold limit.
// Every register advances only on hready=1 edges; reset parks the bus on DEF_MASTER.
module ahb_rr_arbiter #(
    parameter int MAX_HOLD   = 8,
    parameter int DEF_MASTER = 0
) (
    input  logic              hclk,
    input  logic              hresetn,
    ahb_rr_arbiter_if.slave   io_bus
);
    typedef enum logic [1:0] {PARK, OWN, LOCKED} state_t;

    localparam logic [1:0] DEF_IDX  = 2'(DEF_MASTER);
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    function automatic logic [1:0] incMod3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    function automatic logic [2:0] oneHot(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_grantIdx;
    logic [1:0] w_nextIdx;
    logic [2:0] r_hgrant;
    logic [1:0] r_hmaster;
    logic [1:0] r_hmasterData;
    logic [7:0] r_beatCnt;
    logic [1:0] w_idx1;
    logic [1:0] w_idx2;
    logic       w_curReq;
    logic       w_curLock;
    logic       w_othersReq;
    logic       w_counted;

    assign w_idx1      = incMod3(r_grantIdx);
    assign w_idx2      = incMod3(w_idx1);
    assign w_curReq    = |(io_bus.hbusreq & r_hgrant);
    assign w_curLock   = |(io_bus.hbusreq & io_bus.hlock & r_hgrant);
    assign w_othersReq = |(io_bus.hbusreq & ~r_hgrant);
    assign w_counted   = (io_bus.htrans == 2'b10) || (io_bus.htrans == 2'b11);

    // A hold-limit handover only happens if someone else is actually waiting.
    always_comb begin
        w_nextState = PARK;
        w_nextIdx   = DEF_IDX;
        if (w_curLock) begin
            w_nextState = LOCKED;
            w_nextIdx   = r_grantIdx;
        end else if (w_curReq && ((r_beatCnt < HOLD_LIM) || !w_othersReq)) begin
            w_nextState = OWN;
            w_nextIdx   = r_grantIdx;
        end else if (|io_bus.hbusreq) begin
            w_nextState = OWN;
            if (|(io_bus.hbusreq & oneHot(w_idx1))) begin
                w_nextIdx = w_idx1;
            end else if (|(io_bus.hbusreq & oneHot(w_idx2))) begin
                w_nextIdx = w_idx2;
            end else begin
                w_nextIdx = r_grantIdx;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state       <= PARK;
            r_grantIdx    <= DEF_IDX;
            r_hgrant      <= oneHot(DEF_IDX);
            r_hmaster     <= DEF_IDX;
            r_hmasterData <= DEF_IDX;
            r_beatCnt     <= 8'd0;
        end else if (io_bus.hready) begin
            r_state       <= w_nextState;
            r_grantIdx    <= w_nextIdx;
            r_hgrant      <= oneHot(w_nextIdx);
            r_hmaster     <= r_grantIdx;
            r_hmasterData <= r_hmaster;
            if (w_nextIdx != r_grantIdx) begin
                r_beatCnt <= 8'd0;
            end else if (w_counted && (r_beatCnt < HOLD_LIM)) begin
                r_beatCnt <= r_beatCnt + 8'd1;
            end
        end
    end

    // LOCKED is entered exactly when the granted master held hbusreq and hlock at the edge.
    always_comb begin
        io_bus.hgrant       = r_hgrant;
        io_bus.hmaster      = r_hmaster;
        io_bus.hmaster_data = r_hmasterData;
        io_bus.hmastlock    = (r_state == LOCKED);
    end
endmodule

// File: doc/ahb_rr_arbiter.md
AHB_RR_ARBITER -- requirements
Module: ahb_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum number of counted beats an unlocked owner may hold the bus while another master requests (legal 2..255).
REQ-002 Parameter: DEF_MASTER, default 0, index of the master parked on the bus when nobody requests (legal 0..2).
REQ-003 Ports, clock and reset:
- hclk  in  1  clock
- hresetn  in  1  reset
REQ-004 Reset hresetn, asynchronous, active-low; clock hclk.
REQ-005 Request and status ports:
- hbusreq  in  3  bus request, bit i = master i
- hlock  in  3  locked-transfer request, bit i = master i
- htrans  in  2  transfer type of the current address-phase master (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hready  in  1  transfer-done from the selected slave
REQ-006 Grant and ownership ports:
- hgrant  out  3  registered one-hot grant
- hmaster  out  2  address-phase owner index
- hmaster_data  out  2  data-phase owner index
- hmastlock  out  1  current address phase is locked

Function
REQ-007 Internal states SHALL be PARK (no requests; DEF_MASTER granted), OWN (requesting master granted, unlocked) and LOCKED (granted master asserts hbusreq and hlock).
REQ-008 All registers SHALL update only on rising hclk edges where hready=1; they SHALL hold when hready=0.
REQ-009 Arbitration (g = current grant index) SHALL follow this priority:
- hlock[g] & hbusreq[g] -> keep g (LOCKED); MAX_HOLD is ignored.
- hbusreq[g] and (beat_cnt < MAX_HOLD or no other hbusreq bit set) -> keep g (OWN).
- any hbusreq set -> grant the first requester in order g+1, g+2, g (mod 3) (OWN).
- none set -> grant DEF_MASTER (PARK).
REQ-010 hgrant SHALL be exactly one-hot in every cycle.
REQ-011 hmaster SHALL load the index of the hgrant bit that was set at that edge, giving 1 hready-cycle latency from grant to address-phase ownership.
REQ-012 hmaster_data SHALL load the old hmaster value at the same edge.
REQ-013 hmastlock SHALL load hlock[grant index] & hbusreq[grant index] at the same edge.
REQ-014 beat_cnt (8 bits) SHALL reset to 0 on any edge where the grant index changes.
REQ-015 Otherwise beat_cnt SHALL increment on edges with htrans = 10 or 11, saturating at MAX_HOLD.
REQ-016 BUSY (01) and IDLE (00) htrans SHALL not increment beat_cnt.
REQ-017 Request changes while hready=0 SHALL have no effect until the next hready=1 edge.
REQ-018 Simultaneous requests: the round-robin order of REQ-009 SHALL decide; no master may be skipped twice in succession while it requests continuously.
REQ-019 A master dropping hlock while keeping hbusreq SHALL move LOCKED->OWN and keep its current beat_cnt.
REQ-020 hbusreq on an undriven master index SHALL not exist (3 masters fixed); index 3 SHALL never appear on hmaster or hmaster_data.

Reset
REQ-021 While hresetn=0, hgrant SHALL be the one-hot of DEF_MASTER (001 at default), hmaster = hmaster_data = DEF_MASTER, hmastlock = 0, beat_cnt = 0 and the state SHALL be PARK.
REQ-022 Reset asserted mid-transfer SHALL force these values immediately, independent of hclk.
REQ-023 After reset release, the first arbitration SHALL occur at the first hready=1 edge.

Verification
REQ-024 Reset, no requests, hready=1 for 5 cycles -> hgrant=001, hmaster=0, hmastlock=0 throughout.
REQ-025 hbusreq=010 at edge 1, hready=1:
- edge 1 -> hgrant=010.
- edge 2 -> hmaster=1.
- edge 3 -> hmaster_data=1.
REQ-026 hbusreq=111 held, htrans=10 every cycle, MAX_HOLD=8, hready=1 -> grant order 0,1,2,0.
- Each holder keeps the grant exactly 8 counted beats (hgrant changes every 9th edge after the first handover, per REQ-014/015).
REQ-027 Master 2 with hbusreq=100, hlock=100, master 0 requesting, 20 SEQ beats -> hgrant stays 100 and hmastlock=1.
- hlock drops -> hgrant=001 at the first edge where beat_cnt >= 8.
REQ-028 Master 1 owns, hready=0 for 4 cycles while hbusreq changes 010->001 -> outputs frozen.
- hgrant=001 at the first hready=1 edge.
REQ-029 hresetn pulsed low mid-burst with hgrant=100 -> outputs return to reset values asynchronously; beat_cnt=0 after release.
